// File: rtl/histo_ctrl_pkg.sv
// Shared types and constants for the histogram run sequencer.
// Holds the sequencer state encoding, readout word width and header layout.
package histo_ctrl_pkg;

   localparam int         WORD_W    = 32;
   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_WAIT,
      ST_ACQ,
      ST_SETTLE,
      ST_SNAP,
      ST_READ
   } state_t;

   function automatic logic [WORD_W-1:0] mk_header(input logic [15:0] run_cnt,
                                                   input logic [7:0]  nbins);
      return {run_cnt, nbins, HDR_MAGIC};
   endfunction

endpackage

// File: rtl/histo_run_ctrl_run_timer.sv
// Loadable down-counter shared by the WAIT, ACQ and SETTLE phases.
// o_zero is registered and reflects the current count, so it marks the final cycle of a phase.
module run_timer #(
   parameter int W = 32
) (
   input  logic         clkin,
   input  logic         nrst,
   input  logic         i_ld,
   input  logic [W-1:0] i_ld_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         r_cnt  <= '0;
         o_zero <= 1'b1;
      end else if (i_ld) begin
         r_cnt  <= i_ld_val;
         o_zero <= (i_ld_val == '0);
      end else if (i_en && !o_zero) begin
         r_cnt  <= r_cnt - 1'b1;
         o_zero <= (r_cnt == W'(1));
      end
   end

endmodule

// File: rtl/histo_run_ctrl.sv
// Acquisition sequencer: clear histogram, count for run_len cycles, snapshot, stream header + bins.
// Readout words advance only on rd_valid && rd_ready; data and last flag hold while stalled.
module histo_run_ctrl
   import histo_ctrl_pkg::*;
#(
   parameter int NBINS      = 8,
   parameter int CLEAR_WAIT = NBINS + 4,
   parameter int SETTLE     = 2
) (
   input  logic                      clkin,
   input  logic                      nrst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      continuous,
   input  logic [WORD_W-1:0]         run_len,
   input  logic [NBINS*WORD_W-1:0]   histo_in,
   output logic                      resethist,
   output logic                      acquiring,
   output logic                      busy,
   output logic [WORD_W-1:0]         rd_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic                      rd_last,
   output logic                      done,
   output logic                      err_len,
   output logic [15:0]               run_count
);

   localparam int IDX_W = $clog2(NBINS + 1);
   localparam logic [WORD_W-1:0] CLEAR_WAIT_M1 = (CLEAR_WAIT > 0) ? WORD_W'(CLEAR_WAIT - 1) : '0;
   localparam logic [WORD_W-1:0] SETTLE_M1     = (SETTLE > 0)     ? WORD_W'(SETTLE - 1)     : '0;

   state_t            r_state;
   logic [WORD_W-1:0] r_run_len;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_snap [NBINS];

   logic              w_tmr_ld;
   logic              w_tmr_en;
   logic [WORD_W-1:0] w_tmr_val;
   logic              w_tmr_zero;
   logic [IDX_W-1:0]  w_nidx;
   logic [WORD_W-1:0] w_words [NBINS+1];

   run_timer #(.W(WORD_W)) u_timer (
      .clkin    (clkin),
      .nrst     (nrst),
      .i_ld     (w_tmr_ld),
      .i_ld_val (w_tmr_val),
      .i_en     (w_tmr_en),
      .o_zero   (w_tmr_zero)
   );

   // Each timed phase is preloaded with (length-1) in the cycle before it starts.
   always_comb begin
      w_tmr_ld  = 1'b0;
      w_tmr_en  = 1'b0;
      w_tmr_val = '0;
      case (r_state)
         ST_CLEAR: begin
            w_tmr_ld  = 1'b1;
            w_tmr_val = CLEAR_WAIT_M1;
         end
         ST_WAIT: begin
            if (w_tmr_zero) begin
               w_tmr_ld  = 1'b1;
               w_tmr_val = r_run_len - 1'b1;
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         ST_ACQ: begin
            if (w_tmr_zero) begin
               w_tmr_ld  = 1'b1;
               w_tmr_val = SETTLE_M1;
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         ST_SETTLE: w_tmr_en = ~w_tmr_zero;
         default: ;
      endcase
   end

   always_comb begin
      w_words[0] = mk_header(run_count, 8'(NBINS));
      for (int i = 0; i < NBINS; i++) begin
         w_words[i+1] = r_snap[i];
      end
   end

   assign w_nidx = r_idx + 1'b1;

   always_ff @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         r_state   <= ST_IDLE;
         r_run_len <= '0;
         r_idx     <= '0;
         resethist <= 1'b0;
         acquiring <= 1'b0;
         busy      <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         done      <= 1'b0;
         err_len   <= 1'b0;
         run_count <= '0;
         for (int i = 0; i < NBINS; i++) begin
            r_snap[i] <= '0;
         end
      end else begin
         resethist <= 1'b0;
         done      <= 1'b0;
         err_len   <= 1'b0;
         if (abort) begin
            r_state   <= ST_IDLE;
            busy      <= 1'b0;
            acquiring <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     if (run_len == '0) begin
                        err_len <= 1'b1;
                     end else begin
                        r_run_len <= run_len;
                        r_state   <= ST_CLEAR;
                        resethist <= 1'b1;
                        busy      <= 1'b1;
                     end
                  end
               end
               ST_CLEAR: r_state <= ST_WAIT;
               ST_WAIT: begin
                  if (w_tmr_zero) begin
                     r_state   <= ST_ACQ;
                     acquiring <= 1'b1;
                  end
               end
               ST_ACQ: begin
                  if (w_tmr_zero) begin
                     acquiring <= 1'b0;
                     r_state   <= (SETTLE == 0) ? ST_SNAP : ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (w_tmr_zero) r_state <= ST_SNAP;
               end
               ST_SNAP: begin
                  for (int i = 0; i < NBINS; i++) begin
                     r_snap[i] <= histo_in[i*WORD_W +: WORD_W];
                  end
                  r_state  <= ST_READ;
                  r_idx    <= '0;
                  rd_data  <= w_words[0];
                  rd_valid <= 1'b1;
                  rd_last  <= 1'b0;
               end
               ST_READ: begin
                  if (rd_valid && rd_ready) begin
                     if (rd_last) begin
                        rd_valid  <= 1'b0;
                        rd_last   <= 1'b0;
                        run_count <= run_count + 1'b1;
                        if (continuous) begin
                           r_state   <= ST_CLEAR;
                           resethist <= 1'b1;
                        end else begin
                           r_state <= ST_IDLE;
                           busy    <= 1'b0;
                           done    <= 1'b1;
                        end
                     end else begin
                        r_idx   <= w_nidx;
                        rd_data <= w_words[w_nidx];
                        rd_last <= (w_nidx == IDX_W'(NBINS));
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_histo_run_ctrl.sv
// Scoreboard bench for histo_run_ctrl: per-run expected word lists are queued at start,
// a negedge monitor pops and compares every accepted readout word.
module tb_histo_run_ctrl;
   import histo_ctrl_pkg::*;

   localparam int NBINS = 8;
   localparam int CW    = NBINS + 4;
   localparam int ST    = 2;

   logic                    clkin = 1'b0;
   logic                    nrst = 1'b0;
   logic                    start = 1'b0;
   logic                    abort = 1'b0;
   logic                    continuous = 1'b0;
   logic [31:0]             run_len = '0;
   logic [NBINS*32-1:0]     histo_in = '0;
   logic                    rd_ready = 1'b1;
   logic                    resethist, acquiring, busy, rd_valid, rd_last, done, err_len;
   logic [31:0]             rd_data;
   logic [15:0]             run_count;

   histo_run_ctrl #(.NBINS(NBINS), .CLEAR_WAIT(CW), .SETTLE(ST)) dut (
      .clkin(clkin), .nrst(nrst), .start(start), .abort(abort), .continuous(continuous),
      .run_len(run_len), .histo_in(histo_in), .resethist(resethist), .acquiring(acquiring),
      .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_last(rd_last), .done(done), .err_len(err_len), .run_count(run_count)
   );

   always #5 clkin = ~clkin;

   int cyc = 0;
   always @(posedge clkin) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct { logic [31:0] d; logic l; } exp_t;
   exp_t        sb[$];
   logic [31:0] run_vals [NBINS];
   int          model_rc = 0;
   logic        rdy_rand = 1'b0;

   // Expected readout of one complete run: header, then bins in order, last flag on final bin.
   task automatic push_run();
      exp_t e;
      e.d = {16'(model_rc), 8'(NBINS), 8'hA5};
      e.l = 1'b0;
      sb.push_back(e);
      for (int i = 0; i < NBINS; i++) begin
         e.d = run_vals[i];
         e.l = (i == NBINS - 1);
         sb.push_back(e);
      end
      model_rc = (model_rc + 1) % 65536;
   endtask

   // Input drivers: bins show the run's values except while words stream out, when they are scrambled.
   initial forever begin
      @(posedge clkin);
      #1;
      rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < NBINS; i++)
         histo_in[i*32 +: 32] = rd_valid ? 32'($urandom) : run_vals[i];
   end

   int   n_rh = 0, n_done = 0, n_err = 0, n_xfer = 0;
   int   rh_cyc = -1, acq_first = -1, acq_last = -1, rdv_first = -1, done_cyc = -1, last_xfer_cyc = -1;
   logic acq_prev = 1'b0, rdv_prev = 1'b0, stall_prev = 1'b0;
   logic [32:0] stall_dat = '0;

   initial forever begin
      exp_t e;
      @(negedge clkin);
      if (nrst) begin
         if (resethist) begin n_rh++; rh_cyc = cyc; end
         if (acquiring && !acq_prev) acq_first = cyc;
         if (acquiring) acq_last = cyc;
         acq_prev = acquiring;
         if (rd_valid && !rdv_prev) rdv_first = cyc;
         rdv_prev = rd_valid;
         if (done) begin n_done++; done_cyc = cyc; end
         if (err_len) n_err++;
         if (rd_valid) begin
            if (stall_prev) chk("stall_hold", 64'({rd_last, rd_data}), 64'(stall_dat));
            if (rd_ready) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_word: got 0x%0h, expected no word", rd_data);
               end else begin
                  e = sb.pop_front();
                  chk("word", 64'({rd_last, rd_data}), 64'({e.l, e.d}));
               end
               n_xfer++;
               if (rd_last) last_xfer_cyc = cyc;
               stall_prev = 1'b0;
            end else begin
               stall_prev = 1'b1;
               stall_dat  = {rd_last, rd_data};
            end
         end else begin
            stall_prev = 1'b0;
         end
      end else begin
         acq_prev = 1'b0; rdv_prev = 1'b0; stall_prev = 1'b0;
      end
   end

   task automatic issue_start(input logic [31:0] len, output int c0);
      @(posedge clkin); #1;
      run_len = len; start = 1'b1; c0 = cyc;
      @(posedge clkin); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int k = 0;
      @(negedge clkin);
      while (busy && k < budget) begin @(negedge clkin); k++; end
      @(negedge clkin);
      chk({nm, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic wait_xfer(input string nm, input int target, input int budget);
      int k = 0;
      while (n_xfer < target && k < budget) begin @(negedge clkin); k++; end
      chk({nm, "_reach"}, 64'(n_xfer >= target), 64'd1);
   endtask

   task automatic pulse_abort();
      @(posedge clkin); #1; abort = 1'b1;
      @(posedge clkin); #1; abort = 1'b0;
      @(negedge clkin);
   endtask

   task automatic rand_vals();
      for (int i = 0; i < NBINS; i++) run_vals[i] = 32'($urandom);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit hit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, d0, e0, rh0, x0, saved, len, k;

      for (int i = 0; i < NBINS; i++) run_vals[i] = 32'(i + 1);
      repeat (3) @(negedge clkin);
      chk("reset_ctrl", 64'({resethist, acquiring, busy, rd_valid, rd_last, done, err_len}), 64'd0);
      chk("reset_data", 64'({run_count, rd_data}), 64'd0);
      @(posedge clkin); #1; nrst = 1'b1;

      // Directed run with the documented timing.
      d0 = n_done;
      push_run();
      issue_start(100, c0);
      wait_idle("directed", 400);
      chk("t_resethist", 64'(rh_cyc), 64'(c0 + 1));
      chk("t_acq_first", 64'(acq_first), 64'(c0 + 2 + CW));
      chk("t_acq_last", 64'(acq_last), 64'(c0 + 1 + CW + 100));
      chk("t_rdv_first", 64'(rdv_first), 64'(c0 + 3 + CW + 100 + ST));
      chk("t_last_xfer", 64'(last_xfer_cyc), 64'(rdv_first + NBINS));
      chk("t_done", 64'(done_cyc), 64'(last_xfer_cyc + 1));
      chk("directed_done_cnt", 64'(n_done - d0), 64'd1);
      chk("directed_run_count", 64'(run_count), 64'd1);

      // Zero-length request is rejected.
      e0 = n_err;
      issue_start(0, c0);
      @(negedge clkin);
      chk("errlen_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clkin);
      chk("errlen_pulses", 64'(n_err - e0), 64'd1);
      chk("errlen_busy_late", 64'(busy), 64'd0);

      // Abort beats a simultaneous start.
      @(posedge clkin); #1; run_len = 5; start = 1'b1; abort = 1'b1;
      @(posedge clkin); #1; start = 1'b0; abort = 1'b0;
      @(negedge clkin);
      chk("abort_vs_start", 64'({busy, resethist}), 64'd0);

      // Random single-shot runs with a randomly stalling consumer.
      rdy_rand = 1'b1;
      for (int r = 0; r < 6; r++) begin
         rand_vals();
         if (r == 1) begin run_vals[0] = 32'hFFFF_FFFF; run_vals[NBINS-1] = 32'h0; end
         len = (r == 0) ? 1 : $urandom_range(1, 40);
         d0 = n_done;
         push_run();
         issue_start(32'(len), c0);
         wait_idle("rand", CW + len + ST + 300);
         chk("rand_done", 64'(n_done - d0), 64'd1);
         chk("rand_run_count", 64'(run_count), 64'(16'(model_rc)));
      end

      // Abort in the middle of the counting window.
      saved = model_rc; d0 = n_done;
      rand_vals(); push_run();
      issue_start(60, c0);
      k = 0;
      while (!acquiring && k < 100) begin @(negedge clkin); k++; end
      chk("acq_reached", 64'(acquiring), 64'd1);
      repeat (20) @(posedge clkin);
      pulse_abort();
      chk("abort_acq_outs", 64'({busy, rd_valid, acquiring, resethist}), 64'd0);
      chk("abort_acq_rc", 64'(run_count), 64'(16'(saved)));
      sb.delete(); model_rc = saved;
      @(negedge clkin);
      chk("abort_acq_nodone", 64'(n_done - d0), 64'd0);
      rand_vals(); push_run();
      issue_start(25, c0);
      wait_idle("after_abort_acq", 400);
      chk("after_abort_acq_rc", 64'(run_count), 64'(16'(model_rc)));

      // Abort in the middle of readout.
      saved = model_rc; d0 = n_done; x0 = n_xfer;
      rand_vals(); push_run();
      issue_start(20, c0);
      wait_xfer("abort_read", x0 + 4, 400);
      pulse_abort();
      chk("abort_read_outs", 64'({busy, rd_valid, acquiring, resethist}), 64'd0);
      chk("abort_read_rc", 64'(run_count), 64'(16'(saved)));
      sb.delete(); model_rc = saved;
      @(negedge clkin);
      chk("abort_read_nodone", 64'(n_done - d0), 64'd0);
      d0 = n_done;
      rand_vals(); push_run();
      issue_start(12, c0);
      wait_idle("after_abort_read", 400);
      chk("after_abort_read_done", 64'(n_done - d0), 64'd1);
      chk("after_abort_read_rc", 64'(run_count), 64'(16'(model_rc)));

      // Asynchronous reset during readout.
      x0 = n_xfer;
      rand_vals(); push_run();
      issue_start(10, c0);
      wait_xfer("reset_read", x0 + 3, 400);
      @(posedge clkin); #3; nrst = 1'b0;
      #1;
      chk("midreset_ctrl", 64'({resethist, acquiring, busy, rd_valid, rd_last, done, err_len}), 64'd0);
      chk("midreset_data", 64'({run_count, rd_data}), 64'd0);
      sb.delete(); model_rc = 0;
      repeat (2) @(posedge clkin);
      #1; nrst = 1'b1;

      // Continuous mode: three back-to-back runs, headers count 0,1,2.
      rand_vals();
      for (int r = 0; r < 3; r++) push_run();
      rh0 = n_rh; d0 = n_done; x0 = n_xfer;
      continuous = 1'b1;
      issue_start(15, c0);
      wait_xfer("cont", x0 + 2 * (NBINS + 1) + 1, 2000);
      chk("cont_no_done", 64'(n_done - d0), 64'd0);
      chk("cont_clear_next", 64'(rh_cyc), 64'(last_xfer_cyc + 1));
      @(posedge clkin); #1; continuous = 1'b0;
      wait_idle("cont", 400);
      chk("cont_resethist", 64'(n_rh - rh0), 64'd3);
      chk("cont_final_done", 64'(n_done - d0), 64'd1);
      chk("cont_run_count", 64'(run_count), 64'd3);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
